sr_ff_bank: RTL
===============

# sr_ff_bank

Parametrised, edge-triggered bank of WIDTH independent flip-flop channels with a shared run-time mode select (D, T, SR, JK). It generalises the single gated NAND SR latch: state changes only on the rising clock edge, and the S=R=1 case has a defined, configurable resolution instead of an undefined output. The block also raises a registered illegal-condition flag and keeps an optional saturating event counter. It is used wherever the design needs a small group of control flags with set/clear/toggle semantics.

## Interface
- WIDTH, 8, number of channels (1..64)
- RESET_VAL, '0, WIDTH-bit value loaded into q on reset
- SR_POLICY, 0, S=R=1 resolution in SR mode: 0 = hold, 1 = set wins, 2 = reset wins
- CNT_W, 8, width of illegal_cnt (only used with SR_FF_BANK_ILLEGAL_CNT_EN)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  update enable; when 0, all channels hold
- mode  in  2  00 = D, 01 = T, 10 = SR, 11 = JK; sampled every edge
- a  in  WIDTH  per-channel D / T / S / J input
- b  in  WIDTH  per-channel R / K input; ignored in D and T modes
- q  out  WIDTH  registered state
- qbar  out  WIDTH  always ~q, combinational; never equal to q
- illegal  out  1  registered; high for one cycle after an edge where en=1, mode=SR and (a & b) != 0
- illegal_cnt  out  CNT_W  saturating count of illegal edges (macro-dependent)

## Operation
- On reset assertion, immediately: q = RESET_VAL, qbar = ~RESET_VAL, illegal = 0, illegal_cnt = 0. This holds at any point in operation, independent of clk.
- At each rising edge with rst_n=1 and en=1, each channel i computes its next state:
  - D: q = a[i]
  - T: q = q ^ a[i]
  - SR: 00 → hold; 10 → 1; 01 → 0; 11 → SR_POLICY
  - JK: 00 → hold; 10 → 1; 01 → 0; 11 → toggle
- en=0: q holds, illegal is written 0, illegal_cnt holds.
- illegal is re-evaluated on every edge and is not sticky. Several illegal channels in one edge count as one event.
- illegal_cnt increments by 1 per illegal edge and saturates at 2^CNT_W−1 with no wrap.
- A mode change takes effect on the same edge on which it is sampled. No pipeline, no history.

## Timing
- Latency: inputs to q is one edge. q to qbar is combinational.
- illegal and illegal_cnt update on the same edge as the offending q update.
- Reset deassertion is synchronised externally. The first active edge after deassertion is a normal update.

## Configuration
- SR_FF_BANK_ILLEGAL_CNT_EN defined: the counter is built as described above.
- SR_FF_BANK_ILLEGAL_CNT_EN undefined: no counter register, and illegal_cnt is tied to 0. The illegal flag is unaffected.

## Structure
- Package sr_ff_bank_pkg holds:
  - the mode enum: MODE_D, MODE_T, MODE_SR, MODE_JK
  - SR policy constants: SR_HOLD, SR_SET, SR_RESET
- Sub-module sr_ff_cell: one channel (next-state mux plus async-reset register), instantiated WIDTH times with a generate loop. The top level owns illegal detection and the counter.

## Test plan
- Reset: rst_n=0 mid-cycle with RESET_VAL=8'hA5 → q=A5 and qbar=5A immediately, without waiting for an edge; illegal=0; cnt=0.
- D then T: mode=D, a=8'h3C → q=3C. Then mode=T, a=8'hFF for two edges → q=C3, then 3C.
- SR policy:
  - From q=00: mode=SR, a=8'h0F, b=8'hF0 → q=0F.
  - Then a=b=8'h01: SR_POLICY=0 → q=0F; SR_POLICY=2 → q=0E. In both cases illegal=1 for exactly one cycle.
- JK: from q=8'h0F, mode=JK, a=b=8'hFF → q=F0. Same input again → q=0F. illegal stays 0.
- en=0 while driving SR a=b=8'hFF for 3 edges → q unchanged, illegal=0, cnt unchanged.
- Counter (macro on, CNT_W=2): 5 consecutive illegal edges → cnt=1, 2, 3, 3, 3. With the macro off → cnt stays 0.

Source files
------------

// File: rtl/sr_ff_bank_pkg.sv
// Shared types for the sr_ff_bank flag register: mode encoding and S=R=1 policies.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sr_ff_bank_pkg;

  // Run-time channel behaviour, sampled on every edge.
  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_SR = 2'b10,
    MODE_JK = 2'b11
  } mode_e;

  // Resolution of S=R=1 in SR mode.
  localparam int SR_HOLD  = 0;
  localparam int SR_SET   = 1;
  localparam int SR_RESET = 2;

endpackage

// File: rtl/sr_ff_bank_cell.sv
// One flag channel: D/T/SR/JK next-state mux feeding an async-reset register.
// Latency: one rising edge from a_i/b_i/mode_i to q_o.
// Backpressure: none; en_i low holds the state.
module sr_ff_bank_cell
  import sr_ff_bank_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0,
  parameter int   SR_POLICY = SR_HOLD
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  logic  en_i,
  input  mode_e mode_i,
  input  logic  a_i,
  input  logic  b_i,
  output logic  q_o
);

  logic q_q;
  logic q_d;

  // Next state: hold unless enabled, then apply the selected flip-flop rule.
  always_comb begin
    q_d = q_q;
    if (en_i) begin
      unique case (mode_i)
        MODE_D: q_d = a_i;
        MODE_T: q_d = q_q ^ a_i;
        MODE_SR: begin
          unique case ({a_i, b_i})
            2'b10:   q_d = 1'b1;
            2'b01:   q_d = 1'b0;
            2'b11: begin
              if (SR_POLICY == SR_SET)        q_d = 1'b1;
              else if (SR_POLICY == SR_RESET) q_d = 1'b0;
              else                            q_d = q_q;
            end
            default: q_d = q_q;
          endcase
        end
        MODE_JK: begin
          unique case ({a_i, b_i})
            2'b10:   q_d = 1'b1;
            2'b01:   q_d = 1'b0;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
          endcase
        end
        default: q_d = q_q;
      endcase
    end
  end

  // State register; reset forces the configured power-on value immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) q_q <= RESET_VAL;
    else          q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH set/clear/toggle flags with shared mode, registered S=R=1 flag and optional
// saturating illegal-event counter (built only with SR_FF_BANK_ILLEGAL_CNT_EN defined).
// Latency: one edge to q_o/illegal_o/illegal_cnt_o, qbar_o combinational; backpressure: none, en_i=0 holds.
module sr_ff_bank
  import sr_ff_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SR_POLICY = SR_HOLD,
  parameter int               CNT_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qbar_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  mode_e mode;
  logic  illegal_d;
  logic  illegal_q;

  assign mode = mode_e'(mode_i);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_ff_bank_cell #(
      .RESET_VAL (RESET_VAL[i]),
      .SR_POLICY (SR_POLICY)
    ) u_cell (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (en_i),
      .mode_i  (mode),
      .a_i     (a_i[i]),
      .b_i     (b_i[i]),
      .q_o     (q_o[i])
    );
  end

  assign qbar_o = ~q_o;

  // Any channel with S=R=1 on an enabled SR edge is one illegal event.
  assign illegal_d = en_i && (mode == MODE_SR) && (|(a_i & b_i));

  // Illegal flag is re-evaluated every edge, so it is never sticky.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) illegal_q <= 1'b0;
    else          illegal_q <= illegal_d;
  end

  assign illegal_o = illegal_q;

`ifdef SR_FF_BANK_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count illegal edges, sticking at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (illegal_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign illegal_cnt_o = cnt_q;
`else
  assign illegal_cnt_o = '0;
`endif

endmodule
